// File: rtl/mycpu_pkg.sv
// Shared control-flow types for the mycpu fetch path.
// Latency: none, because this file holds declarations only.
// Backpressure: none, because this file holds declarations only.
package mycpu_pkg;

    // Control-flow class coming out of the decoder.
    // Encodings 6 and 7 are reserved and are treated as OP_SEQ.
    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_BR   = 3'd1,
        OP_JMP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HALT = 3'd5
    } cf_op_t;

    // PC register select codes.
    localparam logic [1:0] PS_HOLD = 2'b00;  // keep the PC
    localparam logic [1:0] PS_INC  = 2'b01;  // pc + 1
    localparam logic [1:0] PS_REL  = 2'b10;  // pc + ia_out (signed)
    localparam logic [1:0] PS_ABS  = 2'b11;  // load ra_out

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_HALT     = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pc_seq_ctrl_ras.sv
// Return-address stack: a LIFO with registered storage and a combinational top-of-stack read.
// Latency: rdata shows the current top in the same cycle; a push or pop takes effect at the next edge.
// Backpressure: none. A push while full or a pop while empty is ignored, and the caller flags the error.
// Ports: clk, rst (async, active high; clears sp only), push/pop/wdata in, rdata/full/empty out.
module ras_stack #(
    parameter int DW        = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int AW  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int SPW = AW + 1;

    logic [SPW-1:0] sp;
    logic [DW-1:0]  mem [RAS_DEPTH];
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;

    // The depth is a power of two, so the low bits of sp address the array directly.
    // When the stack is empty, rd_idx wraps to a valid index. Its value is then unused.
    assign wr_idx = sp[AW-1:0];
    assign rd_idx = wr_idx - AW'(1);
    assign full   = (sp == SPW'(RAS_DEPTH));
    assign empty  = (sp == '0);
    assign rdata  = mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

    // Entries are deliberately left unreset. Only sp defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencer: turns decoder control flow into a PC select, an offset and a target, and owns the RAS.
// Latency: the outputs are combinational in the same cycle; a taken redirect adds one flush cycle.
// Backpressure: imem_ready low holds the PC, and the instruction is re-evaluated one cycle after ready returns.
// Ports: clk, rst; decoder inputs instr_valid/op_in/cond_in/offset_in/target_in; pc_in, imem_ready;
//        outputs ps_out/ia_out/ra_out/flush_out/halted/ras_err.
module pc_seq_ctrl
    import mycpu_pkg::*;
#(
    parameter int DW        = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    input  logic [2:0]    op_in,
    input  logic          cond_in,
    input  logic [DW-1:0] offset_in,
    input  logic [DW-1:0] target_in,
    input  logic [DW-1:0] pc_in,
    input  logic          imem_ready,
    output logic [1:0]    ps_out,
    output logic [DW-1:0] ia_out,
    output logic [DW-1:0] ra_out,
    output logic          flush_out,
    output logic          halted,
    output logic          ras_err
);
    seq_state_t    state_q;
    seq_state_t    state_d;
    logic [1:0]    ps;
    logic          flush;
    logic          push;
    logic          pop;
    logic          err_set;
    logic [DW-1:0] ras_rdata;
    logic          ras_full;
    logic          ras_empty;

    ras_stack #(
        .DW        (DW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push & ~rst),
        .pop   (pop & ~rst),
        .wdata (pc_in + DW'(1)),
        .rdata (ras_rdata),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_err <= 1'b0;
        end else if (err_set) begin
            ras_err <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ps      = PS_HOLD;
        ia_out  = '0;
        ra_out  = '0;
        flush   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A memory stall wins over a valid instruction. The instruction is retried after the stall.
                if (!imem_ready) begin
                    state_d = ST_WAIT_MEM;
                end else if (instr_valid) begin
                    case (op_in)
                        OP_BR: begin
                            if (cond_in) begin
                                ps      = PS_REL;
                                ia_out  = offset_in;
                                state_d = ST_FLUSH;
                            end else begin
                                ps = PS_INC;
                            end
                        end
                        OP_JMP: begin
                            ps      = PS_ABS;
                            ra_out  = target_in;
                            state_d = ST_FLUSH;
                        end
                        OP_CALL: begin
                            if (ras_full) begin
                                err_set = 1'b1;
                                state_d = ST_HALT;
                            end else begin
                                push    = 1'b1;
                                ps      = PS_ABS;
                                ra_out  = target_in;
                                state_d = ST_FLUSH;
                            end
                        end
                        OP_RET: begin
                            if (ras_empty) begin
                                err_set = 1'b1;
                                state_d = ST_HALT;
                            end else begin
                                pop     = 1'b1;
                                ps      = PS_ABS;
                                ra_out  = ras_rdata;
                                state_d = ST_FLUSH;
                            end
                        end
                        OP_HALT: begin
                            state_d = ST_HALT;
                        end
                        default: begin
                            // OP_SEQ and the reserved encodings
                            ps = PS_INC;
                        end
                    endcase
                end
            end
            ST_WAIT_MEM: begin
                if (imem_ready) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush   = 1'b1;
                state_d = ST_RUN;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // While rst is high, state is already RUN. Live decoder inputs must still not steer the PC.
    assign ps_out    = rst ? PS_HOLD : ps;
    assign flush_out = flush & ~rst;
    assign halted    = (state_q == ST_HALT) & ~rst;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;
    import mycpu_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          instr_valid = 1'b0;
    logic [2:0]    op_in = 3'd0;
    logic          cond_in = 1'b0;
    logic [DW-1:0] offset_in = '0;
    logic [DW-1:0] target_in = '0;
    logic [DW-1:0] pc_in = '0;
    logic          imem_ready = 1'b1;
    logic [1:0]    ps_out;
    logic [DW-1:0] ia_out;
    logic [DW-1:0] ra_out;
    logic          flush_out;
    logic          halted;
    logic          ras_err;

    pc_seq_ctrl #(.DW(DW), .RAS_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .op_in       (op_in),
        .cond_in     (cond_in),
        .offset_in   (offset_in),
        .target_in   (target_in),
        .pc_in       (pc_in),
        .imem_ready  (imem_ready),
        .ps_out      (ps_out),
        .ia_out      (ia_out),
        .ra_out      (ra_out),
        .flush_out   (flush_out),
        .halted      (halted),
        .ras_err     (ras_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a queue holds the return addresses, plus simple mode flags.
    logic [DW-1:0] m_ras[$];
    bit            m_halt;
    bit            m_flush;
    bit            m_wait;
    bit            m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Asserts reset away from a clock edge and checks the outputs right away.
    // Reset is released just after the next rising edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ps", 32'(ps_out), 32'(PS_HOLD));
        chk("rst_flush", 32'(flush_out), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_ras_err", 32'(ras_err), 32'd0);
        m_ras.delete();
        m_halt  = 1'b0;
        m_flush = 1'b0;
        m_wait  = 1'b0;
        m_err   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Runs one clock cycle: drive the inputs, compare at the falling edge, then advance the model.
    task automatic step(input bit rdy, input bit vld, input logic [2:0] op, input bit cond,
                        input logic [DW-1:0] off, input logic [DW-1:0] tgt, input logic [DW-1:0] pc);
        logic [1:0]    e_ps;
        logic [DW-1:0] e_ia;
        logic [DW-1:0] e_ra;
        bit            e_fl;
        bit            e_halt;
        bit            e_err;
        bit            n_halt;
        bit            n_flush;
        bit            n_wait;
        bit            n_errf;
        logic [DW-1:0] ret_addr;

        imem_ready  = rdy;
        instr_valid = vld;
        op_in       = op;
        cond_in     = cond;
        offset_in   = off;
        target_in   = tgt;
        pc_in       = pc;
        @(negedge clk);

        e_ps = 2'b00; e_ia = '0; e_ra = '0; e_fl = 1'b0;
        e_halt = m_halt; e_err = m_err;
        n_halt = m_halt; n_flush = 1'b0; n_wait = m_wait; n_errf = m_err;
        if (m_halt) begin
            // Stopped. Only reset can leave this state.
        end else if (m_flush) begin
            e_fl = 1'b1;
        end else if (m_wait) begin
            if (rdy) n_wait = 1'b0;
        end else if (!rdy) begin
            n_wait = 1'b1;
        end else if (vld) begin
            if (op == 3'd1 && cond) begin
                e_ps = 2'b10; e_ia = off; n_flush = 1'b1;
            end else if (op == 3'd2) begin
                e_ps = 2'b11; e_ra = tgt; n_flush = 1'b1;
            end else if (op == 3'd3) begin
                if (m_ras.size() < DEPTH) begin
                    m_ras.push_back(pc + 16'd1);
                    e_ps = 2'b11; e_ra = tgt; n_flush = 1'b1;
                end else begin
                    n_errf = 1'b1; n_halt = 1'b1;
                end
            end else if (op == 3'd4) begin
                if (m_ras.size() > 0) begin
                    ret_addr = m_ras.pop_back();
                    e_ps = 2'b11; e_ra = ret_addr; n_flush = 1'b1;
                end else begin
                    n_errf = 1'b1; n_halt = 1'b1;
                end
            end else if (op == 3'd5) begin
                n_halt = 1'b1;
            end else begin
                e_ps = 2'b01;
            end
        end

        chk("ps", 32'(ps_out), 32'(e_ps));
        chk("ia", 32'(ia_out), 32'(e_ia));
        chk("ra", 32'(ra_out), 32'(e_ra));
        chk("flush", 32'(flush_out), 32'(e_fl));
        chk("halted", 32'(halted), 32'(e_halt));
        chk("ras_err", 32'(ras_err), 32'(e_err));

        m_halt = n_halt; m_flush = n_flush; m_wait = n_wait; m_err = n_errf;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        logic [2:0] rop;
        #2;
        do_reset();

        // Sequential fetch
        repeat (3) step(1, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h0100);

        // Taken branch with a negative offset, then the flush, then the return to RUN
        step(1, 1, OP_BR, 1, 16'hFFFC, 16'h0, 16'h0103);
        step(1, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h00FF);
        step(1, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h00FF);
        step(1, 1, OP_BR, 0, 16'hFFFC, 16'h0, 16'h0100);

        // A call followed by a matching return
        step(1, 1, OP_CALL, 0, 16'h0, 16'h0200, 16'h0010);
        step(1, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h0200);
        step(1, 1, OP_RET, 0, 16'h0, 16'h0, 16'h0201);
        step(1, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h0011);

        // Memory stall: three cycles low, then one re-entry cycle
        repeat (3) step(0, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h0012);
        step(1, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h0012);
        step(1, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h0012);

        // The return address wraps to zero
        step(1, 1, OP_CALL, 0, 16'h0, 16'h0300, 16'hFFFF);
        step(1, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h0300);
        step(1, 1, OP_RET, 0, 16'h0, 16'h0, 16'h0301);
        step(1, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h0000);
        step(1, 0, OP_JMP, 0, 16'h0, 16'h1234, 16'h0001);

        // Five nested calls overflow a four-entry stack and halt the sequencer
        for (int i = 0; i < 5; i++) begin
            step(1, 1, OP_CALL, 0, 16'h0, 16'(16'h0400 + i), 16'(16'h0040 + i));
            step(1, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h0);
        end
        step(1, 1, OP_RET, 0, 16'h0, 16'h0, 16'h0);
        step(1, 1, OP_JMP, 0, 16'h0, 16'h0555, 16'h0);
        do_reset();

        // A return on an empty stack
        step(1, 1, OP_RET, 0, 16'h0, 16'h0, 16'h0020);
        step(1, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h0020);
        do_reset();

        // Reset asserted during a flush with two entries on the stack, which empties the stack
        step(1, 1, OP_CALL, 0, 16'h0, 16'h0600, 16'h0060);
        step(1, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h0600);
        step(1, 1, OP_CALL, 0, 16'h0, 16'h0700, 16'h0601);
        do_reset();
        step(1, 1, OP_RET, 0, 16'h0, 16'h0, 16'h0000);
        step(1, 1, OP_SEQ, 0, 16'h0, 16'h0, 16'h0000);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                r = int'($urandom_range(0, 99));
                if      (r < 40) rop = 3'd0;
                else if (r < 60) rop = 3'd1;
                else if (r < 68) rop = 3'd2;
                else if (r < 80) rop = 3'd3;
                else if (r < 92) rop = 3'd4;
                else if (r < 94) rop = 3'd5;
                else             rop = 3'(6 + $urandom_range(0, 1));
                step($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0, rop,
                     1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Program-counter sequencer for the mycpu fetch path. Each cycle it turns the decoder's control-flow class, the branch condition and the instruction-memory handshake into the 2-bit PC select, the relative offset and the absolute target that drive the PC register. It owns a small return-address stack (RAS) for CALL/RET, a one-cycle flush after every taken redirect, and a sticky HALT state. It sits between the decode stage and the PC register.

Parameters:
DW, 16, address/PC width
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  decoded instruction present this cycle
op_in  in  3  control-flow class (cf_op_t)
cond_in  in  1  branch condition, sampled only with OP_BR
offset_in  in  DW  signed relative offset for OP_BR
target_in  in  DW  absolute target for OP_JMP/OP_CALL
pc_in  in  DW  current PC register value
imem_ready  in  1  instruction memory has data for pc_in
ps_out  out  2  PC select: 00 hold, 01 +1, 10 pc+ia, 11 load ra
ia_out  out  DW  relative offset to PC
ra_out  out  DW  absolute address to PC
flush_out  out  1  squash the fetched instruction
halted  out  1  sequencer stopped
ras_err  out  1  sticky: RAS overflow or underflow

Behaviour:
- Reset (async, asserted): state=RUN, RAS empty (sp=0), ras_err=0. While rst is high: ps_out=00, flush_out=0, halted=0.
- ps_out, ia_out, ra_out and flush_out are combinational from state and inputs. The PC register applies ps_out at the next edge.
- Default values: ia_out=0, ra_out=0, flush_out=0.
- States: RUN, WAIT_MEM, FLUSH, HALT.
- RUN, imem_ready=0: ps=00, next state WAIT_MEM. This takes priority over instr_valid.
- RUN, imem_ready=1, instr_valid=0: ps=00, stay in RUN.
- RUN, imem_ready=1, instr_valid=1, by op_in:
  - OP_SEQ: ps=01.
  - OP_BR with cond_in=1: ps=10, ia_out=offset_in, next FLUSH.
  - OP_BR with cond_in=0: ps=01.
  - OP_JMP: ps=11, ra_out=target_in, next FLUSH.
  - OP_CALL, RAS not full: push pc_in+1 (mod 2^DW), ps=11, ra_out=target_in, next FLUSH.
  - OP_CALL, RAS full: no push, ps=00, ras_err=1, next HALT.
  - OP_RET, RAS not empty: ra_out=top entry (combinational, same cycle), pop, ps=11, next FLUSH.
  - OP_RET, RAS empty: ps=00, ras_err=1, next HALT.
  - OP_HALT: ps=00, next HALT.
  - Reserved encodings: handled as OP_SEQ.
- WAIT_MEM: ps=00 while imem_ready=0. When imem_ready=1, return to RUN; the instruction is evaluated in RUN on the following cycle.
- FLUSH: exactly one cycle. ps=00, flush_out=1, decoder inputs ignored, next RUN.
- HALT: ps=00, halted=1, all inputs ignored. Exits only through rst.
- RAS behaviour:
  - LIFO, sp ranges 0..RAS_DEPTH.
  - full when sp==RAS_DEPTH, empty when sp==0.
  - There is no simultaneous push and pop: one op per cycle.
  - Stack contents are not cleared on reset; only sp is cleared.
- Arithmetic: pc_in+1 wraps 0xFFFF->0x0000. Signed offset addition is done in the PC register, not here.
- Reset asserted mid-sequence (any state, including FLUSH or HALT): next state is RUN with an empty RAS once rst deasserts.

Decomposition:
- Shared package mycpu_pkg gets:
  - typedef enum logic[2:0] cf_op_t: OP_SEQ=0, OP_BR=1, OP_JMP=2, OP_CALL=3, OP_RET=4, OP_HALT=5.
  - PC select constants: PS_HOLD=2'b00, PS_INC=2'b01, PS_REL=2'b10, PS_ABS=2'b11.
  - typedef enum seq_state_t for RUN/WAIT_MEM/FLUSH/HALT.
- One sub-module: ras_stack (params DW, RAS_DEPTH).
  - Inputs: push, pop, wdata.
  - Outputs: rdata, full, empty.
  - Registered storage and sp, combinational top-of-stack read.

Test Plan:
- Reset, then OP_SEQ with imem_ready=1 for 3 cycles -> ps_out=01 each cycle, flush_out=0, halted=0.
- OP_BR with cond_in=1, offset_in=0xFFFC -> ps_out=10 and ia_out=0xFFFC that cycle; next cycle ps_out=00 and flush_out=1; then back to RUN. Same with cond_in=0 -> ps_out=01, no flush.
- pc_in=0x0010, OP_CALL with target_in=0x0200 -> ps_out=11, ra_out=0x0200. After the flush, OP_RET -> ps_out=11, ra_out=0x0011, RAS empty again.
- Five nested CALLs with RAS_DEPTH=4 -> fifth call gives ps_out=00, ras_err=1, then halted=1 permanently. OP_RET on an empty RAS after reset -> ras_err=1, halted=1.
- imem_ready low for 3 cycles during OP_SEQ -> ps_out=00 for all 3 cycles plus 1 re-entry cycle, then 01. Also pc_in=0xFFFF CALL -> pushed value is 0x0000.
- Assert rst while in FLUSH with sp=2 -> ps_out=00 immediately. After release, OP_RET -> ras_err=1 (RAS was emptied by reset).
